regn_pipe: RTL and testbench

Parametrised elastic register pipeline with load enable, synchronous preset and flush. It generalises the single load-enable/preset register into DEPTH chained stages of N bits. Each stage carries a valid bit and valid/ready backpressure. It sits between producer and consumer blocks that need fixed-latency retiming with stall support, and reports its occupancy.

---
 rtl/regn_pkg.sv | 19 +
 rtl/regn_stage.sv | 50 +++++
 rtl/regn_pipe.sv | 97 +++++++++
 tb/tb_regn_pipe.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regn_pkg
// Description : Shared constants and helpers for the regn_pipe register
//               pipeline (default sizes, occupancy counter width).
// Revision    : 1.0 - initial release
// ============================================================================
package regn_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Width needed to hold an occupancy value in the range 0..depth.
  function automatic int count_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regn_stage.sv
`default_nettype none
// ============================================================================
// Module      : regn_stage
// Description : One elastic register stage: N-bit data with load enable,
//               a valid flag, synchronous preset/flush and a ready output
//               that lets the stage refill in the cycle it empties.
// Revision    : 1.0 - initial release
// ============================================================================
module regn_stage
  import regn_pkg::*;
#(
  parameter int           N          = DEFAULT_WIDTH,
  parameter logic [N-1:0] PRESET_VAL = {N{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  input  logic         down_ready,
  output logic         valid,
  output logic [N-1:0] data,
  output logic         up_ready
);

  // The stage can take a new beat when it is empty or its occupant is leaving.
  assign up_ready = ~valid | down_ready;

  // Stage state: reset clears, preset loads PRESET_VAL, flush drops only the
  // valid flag, otherwise load from upstream when ready (data only on a beat).
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (pst) begin
      valid <= 1'b0;
      data  <= PRESET_VAL;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (up_ready) begin
      valid <= in_valid;
      if (in_valid) begin
        data <= in_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/regn_pipe.sv
`default_nettype none
// ============================================================================
// Module      : regn_pipe
// Description : DEPTH-stage elastic register pipeline of N-bit beats with
//               valid/ready backpressure, synchronous preset and flush, and
//               an occupancy counter.
// Revision    : 1.0 - initial release
// ============================================================================
module regn_pipe
  import regn_pkg::*;
#(
  parameter int           N          = DEFAULT_WIDTH,
  parameter int           DEPTH      = DEFAULT_DEPTH,
  parameter logic [N-1:0] PRESET_VAL = {N{1'b1}}
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pst,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N-1:0]                    d,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [N-1:0]                    q,
  output logic [count_width(DEPTH)-1:0]   count
);

  localparam int             CW       = count_width(DEPTH);
  localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] vld;
  logic [N-1:0]     dat [DEPTH];
  logic             accept;
  logic             emit;

  // The consumer's ready closes the ready chain at the tail.
  assign rdy[DEPTH] = out_ready;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic         stg_in_valid;
      logic [N-1:0] stg_in_data;

      if (i == 0) begin : g_head
        assign stg_in_valid = in_valid;
        assign stg_in_data  = d;
      end else begin : g_body
        assign stg_in_valid = vld[i-1];
        assign stg_in_data  = dat[i-1];
      end

      regn_stage #(
        .N          (N),
        .PRESET_VAL (PRESET_VAL)
      ) u_stage (
        .clk        (clk),
        .rst        (rst),
        .pst        (pst),
        .flush      (flush),
        .in_valid   (stg_in_valid),
        .in_data    (stg_in_data),
        .down_ready (rdy[i+1]),
        .valid      (vld[i]),
        .data       (dat[i]),
        .up_ready   (rdy[i])
      );
    end
  endgenerate

  // No beat is accepted while any of the clearing controls is active.
  assign in_ready  = rdy[0] & rst & ~pst & ~flush;
  assign out_valid = vld[DEPTH-1];
  assign q         = dat[DEPTH-1];

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  // Occupancy: +1 on accept only, -1 on emit only, cleared by rst/pst/flush.
  always_ff @(posedge clk) begin
    if (!rst || pst || flush) begin
      count <= '0;
    end else if (accept && !emit) begin
      if (count != CNT_FULL) begin
        count <= count + CNT_ONE;
      end
    end else if (emit && !accept) begin
      if (count != '0) begin
        count <= count - CNT_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regn_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_regn_pipe
// Description : Self-checking bench for regn_pipe. A reference model keeps
//               the in-flight beats as a queue of (data, position) pairs and
//               moves them with simple min() arithmetic each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regn_pipe;

  localparam int          N          = 8;
  localparam int          DEPTH      = 4;
  localparam logic [7:0]  PRESET_VAL = 8'hFF;

  logic       clk;
  logic       rst;
  logic       pst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] d;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] q;
  logic [2:0] count;

  int n_checks;
  int n_errors;

  // Reference model: oldest beat first; position 0 is the head stage.
  logic [7:0] mq_data [$];
  int         mq_pos  [$];
  logic [7:0] m_q;

  regn_pipe #(
    .N          (N),
    .DEPTH      (DEPTH),
    .PRESET_VAL (PRESET_VAL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pst       (pst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // A beat moves one place forward unless the place it targets is still
  // occupied after the beat ahead of it has moved.
  function automatic bit m_in_ready();
    int lim;
    int npos;
    if (!rst || pst || flush) return 1'b0;
    lim = out_ready ? DEPTH : DEPTH - 1;
    foreach (mq_pos[k]) begin
      npos = (mq_pos[k] + 1 < lim) ? mq_pos[k] + 1 : lim;
      lim  = npos - 1;
    end
    return lim >= 0;
  endfunction

  function automatic bit m_out_valid();
    return (mq_pos.size() > 0) && (mq_pos[0] == DEPTH - 1);
  endfunction

  function automatic void model_step();
    int         lim;
    int         npos;
    int         nq_pos  [$];
    logic [7:0] nq_data [$];
    if (!rst) begin
      mq_pos.delete();
      mq_data.delete();
      m_q = 8'h00;
    end else if (pst) begin
      mq_pos.delete();
      mq_data.delete();
      m_q = PRESET_VAL;
    end else if (flush) begin
      mq_pos.delete();
      mq_data.delete();
    end else begin
      lim = out_ready ? DEPTH : DEPTH - 1;
      foreach (mq_pos[k]) begin
        npos = (mq_pos[k] + 1 < lim) ? mq_pos[k] + 1 : lim;
        lim  = npos - 1;
        if (npos == DEPTH - 1 && mq_pos[k] != DEPTH - 1) m_q = mq_data[k];
        if (npos < DEPTH) begin
          nq_pos.push_back(npos);
          nq_data.push_back(mq_data[k]);
        end
      end
      if (in_valid && lim >= 0) begin
        nq_pos.push_back(0);
        nq_data.push_back(d);
      end
      mq_pos  = nq_pos;
      mq_data = nq_data;
    end
  endfunction

  task automatic set_in(input bit r, input bit p, input bit f, input bit iv,
                        input logic [7:0] dd, input bit ordy);
    rst       = r;
    pst       = p;
    flush     = f;
    in_valid  = iv;
    d         = dd;
    out_ready = ordy;
  endtask

  task automatic sample();
    @(negedge clk);
    check("q",         32'(q),         32'(m_q));
    check("out_valid", 32'(out_valid), 32'(m_out_valid()));
    check("count",     32'(count),     32'(mq_pos.size()));
    check("in_ready",  32'(in_ready),  32'(m_in_ready()));
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_q      = 8'h00;

    // Reset held with a beat offered
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      sample();
      check("rst_q",        32'(q),         32'h0);
      check("rst_out_valid",32'(out_valid), 32'h0);
      check("rst_count",    32'(count),     32'h0);
      check("rst_in_ready", 32'(in_ready),  32'h0);
      advance();
    end
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    sample();
    check("release_in_ready", 32'(in_ready), 32'h1);
    advance();

    // Streaming 01..08 with out_ready high
    for (int j = 0; j < 12; j++) begin
      set_in(1'b1, 1'b0, 1'b0, (j < 8), 8'(j + 1), 1'b1);
      sample();
      if (j >= 4) begin
        check("stream_q",     32'(q),         32'(j - 3));
        check("stream_valid", 32'(out_valid), 32'h1);
      end
      if (j >= 4 && j < 8) check("stream_count", 32'(count), 32'h4);
      advance();
    end

    // Backpressure: fill 10..13, then stall with one more beat offered
    for (int j = 0; j < 4; j++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 8'(8'h10 + j), 1'b0);
      sample();
      advance();
    end
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 8'h14, 1'b0);
    sample();
    check("full_count",    32'(count),    32'h4);
    check("full_in_ready", 32'(in_ready), 32'h0);
    check("full_q",        32'(q),        32'h10);
    advance();
    for (int j = 0; j < 2; j++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      sample();
      check("drain_q", 32'(q), 32'(8'h10 + j));
      advance();
    end
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    sample();
    check("after_drain_count", 32'(count), 32'h2);
    advance();
    for (int j = 0; j < 6; j++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      sample();
      advance();
    end

    // Preset with three beats in flight
    for (int j = 0; j < 3; j++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 8'(8'h20 + j), 1'b1);
      sample();
      advance();
    end
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    sample();
    check("pst_in_ready", 32'(in_ready), 32'h0);
    advance();
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 1'b1);
    sample();
    check("pst_q",     32'(q),         32'hFF);
    check("pst_valid", 32'(out_valid), 32'h0);
    check("pst_count", 32'(count),     32'h0);
    advance();
    for (int k = 1; k <= 4; k++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      sample();
      if (k == 4) begin
        check("pst_lat_q",     32'(q),         32'h03);
        check("pst_lat_valid", 32'(out_valid), 32'h1);
      end
      advance();
    end

    // Flush together with preset: preset wins
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 8'h44, 1'b1);
    sample();
    advance();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    sample();
    check("flush_pst_q",     32'(q),     32'hFF);
    check("flush_pst_count", 32'(count), 32'h0);
    advance();
    // Reset together with preset: reset wins
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    sample();
    advance();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    sample();
    check("rst_pst_q", 32'(q), 32'h00);
    advance();

    // Simultaneous accept and emit while full
    for (int j = 0; j < 4; j++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 8'(8'h30 + j), 1'b0);
      sample();
      advance();
    end
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 8'h34, 1'b1);
    sample();
    check("full_pass_in_ready", 32'(in_ready), 32'h1);
    advance();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    sample();
    check("full_pass_count", 32'(count), 32'h4);
    check("full_pass_q",     32'(q),     32'h31);
    advance();

    // Randomised traffic with occasional clearing controls
    for (int c = 0; c < 800; c++) begin
      set_in(($urandom_range(0, 99) >= 2),
             ($urandom_range(0, 99) < 2),
             ($urandom_range(0, 99) < 3),
             ($urandom_range(0, 99) < 70),
             8'($urandom),
             ($urandom_range(0, 99) < 60));
      sample();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
